pwm_deadtime_inserter: RTL

//  Downstream stage of the PWM generator IP: converts NUM_PHASES single-ended PWM

---
 rtl/pwm_deadtime_inserter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pwm_deadtime_inserter.sv
// Complementary gate driver with programmable dead time per half-bridge and a
// sticky, synchronized fault latch that forces every gate off until cleared.
module pwm_deadtime_inserter #(
  parameter int NUM_PHASES = 3,
  parameter int DT_WIDTH   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [NUM_PHASES-1:0] pwm_in,
  input  logic [DT_WIDTH-1:0]   dead_time,
  input  logic                  enable,
  input  logic                  fault_n,
  input  logic                  fault_clr,
  output logic [NUM_PHASES-1:0] gate_hi,
  output logic [NUM_PHASES-1:0] gate_lo,
  output logic                  fault_latched
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    HI_ON = 2'd2,
    LO_ON = 2'd3
  } phase_state_t;

  logic [NUM_PHASES-1:0] pwm_q;
  logic                  fault_meta;
  logic                  fault_sync;
  logic [DT_WIDTH-1:0]   dt_eff;
  logic                  hold_idle;

  // A programmed zero still yields one dead cycle so the gates never swap on one edge.
  assign dt_eff    = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;
  assign hold_idle = !enable || fault_latched;

  // Synchronizer flops idle at 1 so reset never looks like a fault; set wins over clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      fault_meta    <= 1'b1;
      fault_sync    <= 1'b1;
      fault_latched <= 1'b0;
    end else begin
      fault_meta <= fault_n;
      fault_sync <= fault_meta;
      if (!fault_sync) begin
        fault_latched <= 1'b1;
      end else if (fault_clr) begin
        fault_latched <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_in;
    end
  end

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
    phase_state_t        state;
    logic                target;
    logic [DT_WIDTH-1:0] cnt;
    logic                hi_r;
    logic                lo_r;

    assign gate_hi[i] = hi_r;
    assign gate_lo[i] = lo_r;

    // Gates are only ever set on the DEAD exit, so hi and lo can never overlap.
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        state  <= IDLE;
        target <= 1'b0;
        cnt    <= '0;
        hi_r   <= 1'b0;
        lo_r   <= 1'b0;
      end else if (hold_idle) begin
        state <= IDLE;
        hi_r  <= 1'b0;
        lo_r  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= DEAD;
            target <= pwm_q[i];
            cnt    <= dt_eff;
            hi_r   <= 1'b0;
            lo_r   <= 1'b0;
          end
          DEAD: begin
            if (pwm_q[i] != target) begin
              target <= pwm_q[i];
              cnt    <= dt_eff;
            end else if (cnt <= DT_WIDTH'(1)) begin
              state <= target ? HI_ON : LO_ON;
              hi_r  <= target;
              lo_r  <= !target;
            end else begin
              cnt <= cnt - DT_WIDTH'(1);
            end
          end
          HI_ON: begin
            if (!pwm_q[i]) begin
              state  <= DEAD;
              target <= 1'b0;
              cnt    <= dt_eff;
              hi_r   <= 1'b0;
            end
          end
          LO_ON: begin
            if (pwm_q[i]) begin
              state  <= DEAD;
              target <= 1'b1;
              cnt    <= dt_eff;
              lo_r   <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            hi_r  <= 1'b0;
            lo_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
